// File: rtl/wb_commit_queue.sv
// Register-file write-back commit queue.
// Accepts up to two results per cycle (port 0 older than port 1) and holds
// them in program order in a small FIFO. It drains one regfile write per
// cycle and forwards pending values to the decode read ports.
module wb_commit_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exe_i_valid,
  input  logic                     exe_i_reg_wen,
  input  logic [4:0]               exe_i_reg_rd,
  input  logic [XLEN-1:0]          exe_i_reg_data,
  input  logic                     mem_i_valid,
  input  logic                     mem_i_reg_wen,
  input  logic [4:0]               mem_i_reg_rd,
  input  logic [XLEN-1:0]          mem_i_reg_data,
  output logic                     wbq_o_ready,
  output logic                     write_back_o_reg_wen,
  output logic [4:0]               write_back_o_reg_rd,
  output logic [XLEN-1:0]          write_back_o_reg_data,
  input  logic [4:0]               decode_i_read_rs1,
  input  logic [4:0]               decode_i_read_rs2,
  output logic                     wbq_o_fwdA_hit,
  output logic [XLEN-1:0]          wbq_o_fwdA_data,
  output logic                     wbq_o_fwdB_hit,
  output logic [XLEN-1:0]          wbq_o_fwdB_data,
  output logic [$clog2(DEPTH):0]   wbq_o_count,
  output logic [63:0]              wbq_o_retire_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Ready is held while there is room for a simultaneous dual push.
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [4:0]      rd_q   [DEPTH];
  logic [4:0]      rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW-1:0]   slot1;
  logic [AW:0]     count_q, count_d;
  logic [63:0]     retire_q, retire_d;
  logic            ready;
  logic            push0, push1, pop;

  // Handshake, filtering and drain decisions for this cycle.
  always_comb begin
    ready = (count_q <= READY_MAX);
    push0 = !rst && exe_i_valid && ready && exe_i_reg_wen && (exe_i_reg_rd != '0);
    push1 = !rst && mem_i_valid && ready && mem_i_reg_wen && (mem_i_reg_rd != '0);
    pop   = !rst && (count_q != '0);
  end

  // Next-state for payload storage, pointers, occupancy and retire counter.
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    // Port 1 lands just behind port 0 when both enqueue.
    slot1  = tail_q + AW'(push0);
    if (push0) begin
      rd_d[tail_q]   = exe_i_reg_rd;
      data_d[tail_q] = exe_i_reg_data;
    end
    if (push1) begin
      rd_d[slot1]   = mem_i_reg_rd;
      data_d[slot1] = mem_i_reg_data;
    end
    tail_d   = tail_q + AW'(push0) + AW'(push1);
    head_d   = head_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
    retire_d = retire_q + 64'(pop);
  end

  // Control state with synchronous reset; reset discards pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      retire_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      retire_q <= retire_d;
    end
  end

  // Payload storage; validity is defined by head/count, so no reset needed.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  // Head entry drives the regfile write port; idle port is all zeros.
  always_comb begin
    write_back_o_reg_wen  = pop;
    write_back_o_reg_rd   = pop ? rd_q[head_q]   : '0;
    write_back_o_reg_data = pop ? data_q[head_q] : '0;
  end

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin : fwd_search
    logic [AW-1:0] idx;
    wbq_o_fwdA_hit  = 1'b0;
    wbq_o_fwdA_data = '0;
    wbq_o_fwdB_hit  = 1'b0;
    wbq_o_fwdB_data = '0;
    idx             = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if ((decode_i_read_rs1 != '0) && (rd_q[idx] == decode_i_read_rs1)) begin
          wbq_o_fwdA_hit  = 1'b1;
          wbq_o_fwdA_data = data_q[idx];
        end
        if ((decode_i_read_rs2 != '0) && (rd_q[idx] == decode_i_read_rs2)) begin
          wbq_o_fwdB_hit  = 1'b1;
          wbq_o_fwdB_data = data_q[idx];
        end
      end
    end
  end

  assign wbq_o_ready      = ready;
  assign wbq_o_count      = count_q;
  assign wbq_o_retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: a table of hand-derived vectors,
// a queue-based scoreboard of expected regfile writes, and hand-written
// sequences for backpressure and mid-operation reset.
module tb_wb_commit_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  logic            clk;
  logic            rst;
  logic            exe_i_valid, exe_i_reg_wen;
  logic [4:0]      exe_i_reg_rd;
  logic [XLEN-1:0] exe_i_reg_data;
  logic            mem_i_valid, mem_i_reg_wen;
  logic [4:0]      mem_i_reg_rd;
  logic [XLEN-1:0] mem_i_reg_data;
  logic            wbq_o_ready;
  logic            write_back_o_reg_wen;
  logic [4:0]      write_back_o_reg_rd;
  logic [XLEN-1:0] write_back_o_reg_data;
  logic [4:0]      decode_i_read_rs1, decode_i_read_rs2;
  logic            wbq_o_fwdA_hit, wbq_o_fwdB_hit;
  logic [XLEN-1:0] wbq_o_fwdA_data, wbq_o_fwdB_data;
  logic [2:0]      wbq_o_count;
  logic [63:0]     wbq_o_retire_cnt;

  wb_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .exe_i_valid(exe_i_valid), .exe_i_reg_wen(exe_i_reg_wen),
    .exe_i_reg_rd(exe_i_reg_rd), .exe_i_reg_data(exe_i_reg_data),
    .mem_i_valid(mem_i_valid), .mem_i_reg_wen(mem_i_reg_wen),
    .mem_i_reg_rd(mem_i_reg_rd), .mem_i_reg_data(mem_i_reg_data),
    .wbq_o_ready(wbq_o_ready),
    .write_back_o_reg_wen(write_back_o_reg_wen),
    .write_back_o_reg_rd(write_back_o_reg_rd),
    .write_back_o_reg_data(write_back_o_reg_data),
    .decode_i_read_rs1(decode_i_read_rs1), .decode_i_read_rs2(decode_i_read_rs2),
    .wbq_o_fwdA_hit(wbq_o_fwdA_hit), .wbq_o_fwdA_data(wbq_o_fwdA_data),
    .wbq_o_fwdB_hit(wbq_o_fwdB_hit), .wbq_o_fwdB_data(wbq_o_fwdB_data),
    .wbq_o_count(wbq_o_count), .wbq_o_retire_cnt(wbq_o_retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic ev; logic ew; logic [4:0] erd; logic [63:0] ed;
    logic mv; logic mw; logic [4:0] mrd; logic [63:0] md;
    logic [4:0] rs1; logic [4:0] rs2;
    logic xwen; logic [4:0] xrd; logic [63:0] xdata;
    logic xha; logic [63:0] xda; logic xhb; logic [63:0] xdb;
    logic [2:0] xcnt;
  } vec_t;

  ent_t        sb[$];
  logic [63:0] model_retire;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic ew, input logic [4:0] erd, input logic [63:0] ed,
                       input logic mv, input logic mw, input logic [4:0] mrd, input logic [63:0] md);
    exe_i_valid = ev; exe_i_reg_wen = ew; exe_i_reg_rd = erd; exe_i_reg_data = ed;
    mem_i_valid = mv; mem_i_reg_wen = mw; mem_i_reg_rd = mrd; mem_i_reg_data = md;
  endtask

  function automatic void fwd_model(input logic [4:0] rs, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0)
      foreach (sb[i])
        if (sb[i].rd == rs) begin
          hit = 1'b1;
          d   = sb[i].data;
        end
  endfunction

  // Called at +1 after a rising edge with inputs already driven.
  task automatic cycle_check(input string tag);
    logic h; logic [63:0] d;
    #3;
    chk({tag, "_count"}, 64'(wbq_o_count), 64'(sb.size()));
    chk({tag, "_ready"}, 64'(wbq_o_ready), 64'(sb.size() <= DEPTH - 2));
    if (sb.size() > 0) begin
      chk({tag, "_wen"},  64'(write_back_o_reg_wen), 64'd1);
      chk({tag, "_rd"},   64'(write_back_o_reg_rd), 64'(sb[0].rd));
      chk({tag, "_data"}, write_back_o_reg_data, sb[0].data);
    end else begin
      chk({tag, "_wen"},  64'(write_back_o_reg_wen), 64'd0);
      chk({tag, "_rd"},   64'(write_back_o_reg_rd), 64'd0);
      chk({tag, "_data"}, write_back_o_reg_data, 64'd0);
    end
    fwd_model(decode_i_read_rs1, h, d);
    chk({tag, "_fwdA_hit"},  64'(wbq_o_fwdA_hit), 64'(h));
    chk({tag, "_fwdA_data"}, wbq_o_fwdA_data, d);
    fwd_model(decode_i_read_rs2, h, d);
    chk({tag, "_fwdB_hit"},  64'(wbq_o_fwdB_hit), 64'(h));
    chk({tag, "_fwdB_data"}, wbq_o_fwdB_data, d);
    chk({tag, "_retire"}, wbq_o_retire_cnt, model_retire);
  endtask

  // Update the scoreboard for this cycle, then step to +1 after the edge.
  task automatic cycle_advance();
    bit   do_pop;
    ent_t e;
    do_pop = (sb.size() > 0);
    if (sb.size() <= DEPTH - 2) begin
      if (exe_i_valid && exe_i_reg_wen && exe_i_reg_rd != 5'd0) begin
        e.rd = exe_i_reg_rd; e.data = exe_i_reg_data; sb.push_back(e);
      end
      if (mem_i_valid && mem_i_reg_wen && mem_i_reg_rd != 5'd0) begin
        e.rd = mem_i_reg_rd; e.data = mem_i_reg_data; sb.push_back(e);
      end
    end
    if (do_pop) begin
      void'(sb.pop_front());
      model_retire++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];

  initial begin
    int idx, guard;
    bit seen_low;
    checks = 0; failures = 0; model_retire = '0;
    rst = 1'b1;
    decode_i_read_rs1 = '0; decode_i_read_rs2 = '0;
    drive(1'b1, 1'b1, 5'd4, 64'h99, 1'b1, 1'b1, 5'd6, 64'h98);

    //          ev    ew    erd    ed          mv    mw    mrd     md          rs1    rs2     xwen  xrd    xdata        xha   xda          xhb   xdb          xcnt
    tbl[0] = '{1'b1, 1'b1, 5'd5, 64'hAA,     1'b0, 1'b0, 5'd0,  64'h0,     5'd5, 5'd0,  1'b0, 5'd0,  64'h0,     1'b0, 64'h0,     1'b0, 64'h0,     3'd0};
    tbl[1] = '{1'b0, 1'b0, 5'd0, 64'h0,      1'b0, 1'b0, 5'd0,  64'h0,     5'd5, 5'd0,  1'b1, 5'd5,  64'hAA,    1'b1, 64'hAA,    1'b0, 64'h0,     3'd1};
    tbl[2] = '{1'b1, 1'b1, 5'd3, 64'h11,     1'b1, 1'b1, 5'd3,  64'h22,    5'd3, 5'd0,  1'b0, 5'd0,  64'h0,     1'b0, 64'h0,     1'b0, 64'h0,     3'd0};
    tbl[3] = '{1'b0, 1'b0, 5'd0, 64'h0,      1'b0, 1'b0, 5'd0,  64'h0,     5'd3, 5'd0,  1'b1, 5'd3,  64'h11,    1'b1, 64'h22,    1'b0, 64'h0,     3'd2};
    tbl[4] = '{1'b1, 1'b1, 5'd0, 64'hFF,     1'b1, 1'b0, 5'd7,  64'h77,    5'd3, 5'd7,  1'b1, 5'd3,  64'h22,    1'b1, 64'h22,    1'b0, 64'h0,     3'd1};
    tbl[5] = '{1'b0, 1'b0, 5'd0, 64'h0,      1'b0, 1'b0, 5'd0,  64'h0,     5'd7, 5'd0,  1'b0, 5'd0,  64'h0,     1'b0, 64'h0,     1'b0, 64'h0,     3'd0};
    tbl[6] = '{1'b1, 1'b1, 5'd9, 64'h1234,   1'b1, 1'b1, 5'd11, 64'h5555,  5'd9, 5'd10, 1'b0, 5'd0,  64'h0,     1'b0, 64'h0,     1'b0, 64'h0,     3'd0};
    tbl[7] = '{1'b0, 1'b0, 5'd0, 64'h0,      1'b0, 1'b0, 5'd0,  64'h0,     5'd9, 5'd10, 1'b1, 5'd9,  64'h1234,  1'b1, 64'h1234,  1'b0, 64'h0,     3'd2};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 64'h0,      1'b0, 1'b0, 5'd0,  64'h0,     5'd0, 5'd11, 1'b1, 5'd11, 64'h5555,  1'b0, 64'h0,     1'b1, 64'h5555,  3'd1};
    tbl[9] = '{1'b0, 1'b0, 5'd0, 64'h0,      1'b0, 1'b0, 5'd0,  64'h0,     5'd9, 5'd0,  1'b0, 5'd0,  64'h0,     1'b0, 64'h0,     1'b0, 64'h0,     3'd0};

    // Initial reset with valids presented; they must be ignored.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
    #3;
    chk("reset_ready",  64'(wbq_o_ready), 64'd1);
    chk("reset_wen",    64'(write_back_o_reg_wen), 64'd0);
    chk("reset_rd",     64'(write_back_o_reg_rd), 64'd0);
    chk("reset_data",   write_back_o_reg_data, 64'd0);
    chk("reset_hitA",   64'(wbq_o_fwdA_hit), 64'd0);
    chk("reset_hitB",   64'(wbq_o_fwdB_hit), 64'd0);
    chk("reset_count",  64'(wbq_o_count), 64'd0);
    chk("reset_retire", wbq_o_retire_cnt, 64'd0);
    @(posedge clk);
    #1;

    // Table: single write, dual-issue ordering, filtering, forward hit/miss.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ev, tbl[i].ew, tbl[i].erd, tbl[i].ed, tbl[i].mv, tbl[i].mw, tbl[i].mrd, tbl[i].md);
      decode_i_read_rs1 = tbl[i].rs1;
      decode_i_read_rs2 = tbl[i].rs2;
      cycle_check($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_x_wen", i),  64'(write_back_o_reg_wen), 64'(tbl[i].xwen));
      chk($sformatf("tbl%0d_x_rd", i),   64'(write_back_o_reg_rd), 64'(tbl[i].xrd));
      chk($sformatf("tbl%0d_x_data", i), write_back_o_reg_data, tbl[i].xdata);
      chk($sformatf("tbl%0d_x_hitA", i), 64'(wbq_o_fwdA_hit), 64'(tbl[i].xha));
      chk($sformatf("tbl%0d_x_datA", i), wbq_o_fwdA_data, tbl[i].xda);
      chk($sformatf("tbl%0d_x_hitB", i), 64'(wbq_o_fwdB_hit), 64'(tbl[i].xhb));
      chk($sformatf("tbl%0d_x_datB", i), wbq_o_fwdB_data, tbl[i].xdb);
      chk($sformatf("tbl%0d_x_cnt", i),  64'(wbq_o_count), 64'(tbl[i].xcnt));
      chk($sformatf("tbl%0d_x_ready", i), 64'(wbq_o_ready), 64'd1);
      cycle_advance();
    end
    chk("tbl_retire_total", wbq_o_retire_cnt, 64'd5);

    // Reset mid-operation with three entries pending.
    decode_i_read_rs1 = 5'd21; decode_i_read_rs2 = 5'd23;
    drive(1'b1, 1'b1, 5'd20, 64'h2020, 1'b1, 1'b1, 5'd21, 64'h2121);
    cycle_check("mr0"); cycle_advance();
    drive(1'b1, 1'b1, 5'd22, 64'h2222, 1'b1, 1'b1, 5'd23, 64'h2323);
    cycle_check("mr1"); cycle_advance();
    chk("mr_pending", 64'(wbq_o_count), 64'd3);
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd25, 64'h2525, 1'b0, 1'b0, 5'd0, 64'h0);
    #3;
    chk("mr_rst_wen", 64'(write_back_o_reg_wen), 64'd0);
    @(posedge clk);
    #1;
    sb.delete();
    model_retire = '0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      cycle_check($sformatf("mr_after%0d", i));
      cycle_advance();
    end
    chk("mr_retire", wbq_o_retire_cnt, 64'd0);

    // Backpressure: both ports valid every cycle, rd 1..12, held while not ready.
    idx = 1; guard = 0; seen_low = 1'b0;
    decode_i_read_rs1 = 5'd4; decode_i_read_rs2 = 5'd7;
    while (idx <= 12 && guard < 100) begin
      bit accept;
      drive(1'b1, 1'b1, 5'(idx), 64'(idx) * 64'h101, 1'b1, 1'b1, 5'(idx + 1), 64'(idx + 1) * 64'h101);
      accept = (sb.size() <= DEPTH - 2);
      if (!wbq_o_ready) seen_low = 1'b1;
      cycle_check($sformatf("bp%0d", guard));
      cycle_advance();
      if (accept) idx += 2;
      guard++;
    end
    chk("bp_issue_timeout", 64'(guard < 100), 64'd1);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      cycle_check($sformatf("bpd%0d", guard));
      cycle_advance();
      guard++;
    end
    chk("bp_drain_timeout", 64'(guard < 20), 64'd1);
    cycle_check("bp_idle");
    chk("bp_ready_dropped", 64'(seen_low), 64'd1);
    chk("bp_retire", wbq_o_retire_cnt, 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
